// File: rtl/ch_demux.sv
// Transmit-side channel deinterleaver: collects one 16-bit word per active channel
// from a show-ahead FIFO into holding registers and presents the frame on strobe.
module ch_demux (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic [3:0]  channels,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        sample_strobe,
  output logic [15:0] dout0,
  output logic [15:0] dout1,
  output logic [15:0] dout2,
  output logic [15:0] dout3,
  output logic [15:0] dout4,
  output logic [15:0] dout5,
  output logic [15:0] dout6,
  output logic [15:0] dout7,
  output logic        dout_valid,
  output logic        underrun,
  input  logic        clear_status
);

  localparam int DATA_W = 16;
  localparam int NCH    = 8;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic        [2:0]         idx_q, idx_d;
  logic        [3:0]         nch_q, nch_d;
  logic signed [DATA_W-1:0]  hold_q [NCH];
  logic signed [DATA_W-1:0]  hold_d [NCH];
  logic signed [DATA_W-1:0]  dout_q [NCH];
  logic signed [DATA_W-1:0]  dout_d [NCH];
  logic                      dvld_q, dvld_d;
  logic                      und_q, und_d;
  logic                      accept;
  logic                      last_word;

  // Zero and out-of-range counts mean "all eight channels".
  function automatic logic [3:0] sanitize(input logic [3:0] ch);
    if (ch == 4'd0 || ch > 4'd8) return 4'd8;
    return ch;
  endfunction

  // At the start of a frame the live channel count is used, so the first word
  // of a new frame already sees the count it will be latched with.
  always_comb begin
    nch_d = nch_q;
    if (state_q == FILL && idx_q == 3'd0) nch_d = sanitize(channels);
  end

  assign din_ready = (state_q == FILL) && !reset && !clear;
  assign accept    = din_ready && din_valid;
  assign last_word = ({1'b0, idx_q} == (nch_d - 4'd1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dvld_d  = 1'b0;
    und_d   = und_q & ~clear_status;
    for (int k = 0; k < NCH; k++) begin
      hold_d[k] = hold_q[k];
      dout_d[k] = dout_q[k];
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          hold_d[idx_q] = din;
          if (last_word) begin
            idx_d   = 3'd0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        // Strobe before the frame is complete: emit silence, keep filling.
        if (sample_strobe) begin
          for (int k = 0; k < NCH; k++) dout_d[k] = '0;
          dvld_d = 1'b1;
          und_d  = 1'b1;
        end
      end
      FULL: begin
        if (sample_strobe) begin
          for (int k = 0; k < NCH; k++)
            dout_d[k] = (k < int'(nch_q)) ? hold_q[k] : '0;
          dvld_d  = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Register stage: control and data all flushed by reset/clear.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_q <= FILL;
      idx_q   <= 3'd0;
      nch_q   <= sanitize(channels);
      dvld_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        hold_q[k] <= '0;
        dout_q[k] <= '0;
      end
      if (reset) und_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nch_q   <= nch_d;
      dvld_q  <= dvld_d;
      und_q   <= und_d;
      for (int k = 0; k < NCH; k++) begin
        hold_q[k] <= hold_d[k];
        dout_q[k] <= dout_d[k];
      end
    end
  end

  assign dout0      = dout_q[0];
  assign dout1      = dout_q[1];
  assign dout2      = dout_q[2];
  assign dout3      = dout_q[3];
  assign dout4      = dout_q[4];
  assign dout5      = dout_q[5];
  assign dout6      = dout_q[6];
  assign dout7      = dout_q[7];
  assign dout_valid = dvld_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_ch_demux.sv
// Directed bench for ch_demux: per-cycle vector table plus hand-written
// sequences for a full 8-channel frame and a gappy FIFO.
module tb_ch_demux;

  logic        clock = 1'b0;
  logic        reset, clear, din_valid, din_ready, sample_strobe;
  logic        dout_valid, underrun, clear_status;
  logic [3:0]  channels;
  logic [15:0] din;
  logic [15:0] dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7;
  logic [15:0] douts [8];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ch_demux dut (
    .clock(clock), .reset(reset), .clear(clear), .channels(channels),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sample_strobe(sample_strobe),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .dout4(dout4), .dout5(dout5), .dout6(dout6), .dout7(dout7),
    .dout_valid(dout_valid), .underrun(underrun), .clear_status(clear_status)
  );

  always_comb begin
    douts[0] = dout0; douts[1] = dout1; douts[2] = dout2; douts[3] = dout3;
    douts[4] = dout4; douts[5] = dout5; douts[6] = dout6; douts[7] = dout7;
  end

  typedef struct {
    logic        rst, clr;
    logic [3:0]  ch;
    logic [15:0] din;
    logic        dv, stb, cs;
    logic        e_rdy, e_dvld, e_und;
    logic [15:0] e_d0, e_d1, e_d3, e_d7;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(input logic rst, input logic clr, input logic [3:0] ch,
                              input logic [15:0] d, input logic dv, input logic stb,
                              input logic cs, input logic e_rdy, input logic e_dvld,
                              input logic e_und, input logic [15:0] e_d0,
                              input logic [15:0] e_d1, input logic [15:0] e_d3,
                              input logic [15:0] e_d7);
    vec_t v;
    v.rst = rst; v.clr = clr; v.ch = ch; v.din = d; v.dv = dv; v.stb = stb; v.cs = cs;
    v.e_rdy = e_rdy; v.e_dvld = e_dvld; v.e_und = e_und;
    v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_d3 = e_d3; v.e_d7 = e_d7;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic clr, input logic [3:0] ch,
                       input logic [15:0] d, input logic dv, input logic stb,
                       input logic cs);
    reset = rst; clear = clr; channels = ch; din = d;
    din_valid = dv; sample_strobe = stb; clear_status = cs;
  endtask

  initial begin
    int accepted;
    int cyc;
    drive(1'b1, 1'b0, 4'd2, 16'h0, 1'b0, 1'b0, 1'b0);

    //          rst clr ch    din      dv stb cs  rdy dvld und  d0       d1       d3       d7
    tbl[0]  = mk(1, 0, 4'd2, 16'h0000, 0, 0, 0,  0,  0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, 0, 4'd2, 16'hAAAA, 1, 0, 0,  1,  0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 0, 4'd2, 16'h5555, 1, 0, 0,  1,  0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[3]  = mk(0, 0, 4'd2, 16'h1111, 1, 1, 0,  0,  1,  0, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);
    tbl[4]  = mk(0, 0, 4'd2, 16'h1111, 1, 0, 0,  1,  0,  0, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);
    tbl[5]  = mk(0, 0, 4'd2, 16'h2222, 1, 0, 0,  1,  0,  0, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);
    tbl[6]  = mk(0, 0, 4'd2, 16'h3333, 0, 1, 0,  0,  1,  0, 16'h1111, 16'h2222, 16'h0000, 16'h0000);
    tbl[7]  = mk(0, 0, 4'd4, 16'h0000, 0, 0, 0,  1,  0,  0, 16'h1111, 16'h2222, 16'h0000, 16'h0000);
    tbl[8]  = mk(0, 0, 4'd4, 16'h0A01, 1, 0, 0,  1,  0,  0, 16'h1111, 16'h2222, 16'h0000, 16'h0000);
    tbl[9]  = mk(0, 0, 4'd4, 16'h0A02, 1, 0, 0,  1,  0,  0, 16'h1111, 16'h2222, 16'h0000, 16'h0000);
    tbl[10] = mk(0, 0, 4'd4, 16'h0000, 0, 1, 0,  1,  1,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[11] = mk(0, 0, 4'd4, 16'h0A03, 1, 0, 0,  1,  0,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[12] = mk(0, 0, 4'd4, 16'h0A04, 1, 0, 0,  1,  0,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[13] = mk(0, 0, 4'd4, 16'h0000, 0, 1, 0,  0,  1,  1, 16'h0A01, 16'h0A02, 16'h0A04, 16'h0000);
    tbl[14] = mk(0, 0, 4'd4, 16'h0000, 0, 0, 1,  1,  0,  0, 16'h0A01, 16'h0A02, 16'h0A04, 16'h0000);
    tbl[15] = mk(0, 0, 4'd1, 16'h0B01, 1, 1, 0,  1,  1,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[16] = mk(0, 0, 4'd1, 16'h0000, 0, 1, 1,  0,  1,  0, 16'h0B01, 16'h0000, 16'h0000, 16'h0000);
    tbl[17] = mk(0, 0, 4'd1, 16'h0000, 0, 1, 1,  1,  1,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[18] = mk(0, 0, 4'd8, 16'h0C00, 1, 0, 0,  1,  0,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[19] = mk(0, 0, 4'd8, 16'h0C01, 1, 0, 0,  1,  0,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[20] = mk(0, 0, 4'd8, 16'h0C02, 1, 0, 0,  1,  0,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[21] = mk(0, 1, 4'd3, 16'hDEAD, 1, 1, 0,  0,  0,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[22] = mk(0, 0, 4'd3, 16'h0D00, 1, 0, 0,  1,  0,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[23] = mk(0, 0, 4'd3, 16'h0D01, 1, 0, 0,  1,  0,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[24] = mk(0, 0, 4'd3, 16'h0D02, 1, 0, 0,  1,  0,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[25] = mk(0, 0, 4'd3, 16'h0000, 0, 1, 0,  0,  1,  1, 16'h0D00, 16'h0D01, 16'h0000, 16'h0000);
    tbl[26] = mk(1, 0, 4'd3, 16'h0000, 0, 1, 0,  0,  0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    for (int i = 0; i < 27; i++) begin
      @(negedge clock);
      drive(tbl[i].rst, tbl[i].clr, tbl[i].ch, tbl[i].din, tbl[i].dv, tbl[i].stb, tbl[i].cs);
      #1;
      chk("din_ready", i, {15'd0, din_ready}, {15'd0, tbl[i].e_rdy});
      @(posedge clock);
      #1;
      chk("dout_valid", i, {15'd0, dout_valid}, {15'd0, tbl[i].e_dvld});
      chk("underrun", i, {15'd0, underrun}, {15'd0, tbl[i].e_und});
      chk("dout0", i, dout0, tbl[i].e_d0);
      chk("dout1", i, dout1, tbl[i].e_d1);
      chk("dout3", i, dout3, tbl[i].e_d3);
      chk("dout7", i, dout7, tbl[i].e_d7);
    end

    // Full 8-channel frame, back-to-back words.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 4'd8, 16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0);
      #1;
      chk("basic_ready", i, {15'd0, din_ready}, 16'd1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 4'd8, 16'hEEEE, 1'b1, 1'b0, 1'b0);
      #1;
      chk("full_ready", i, {15'd0, din_ready}, 16'd0);
      chk("full_dvld", i, {15'd0, dout_valid}, 16'd0);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 4'd8, 16'hEEEE, 1'b1, 1'b1, 1'b0);
    #1;
    chk("strobe_ready", 0, {15'd0, din_ready}, 16'd0);
    @(posedge clock);
    #1;
    chk("basic_dvld", 0, {15'd0, dout_valid}, 16'd1);
    for (int k = 0; k < 8; k++) chk("basic_dout", k, douts[k], 16'h1000 + 16'(k));
    @(negedge clock);
    drive(1'b0, 1'b0, 4'd8, 16'hEEEE, 1'b0, 1'b0, 1'b0);
    #1;
    chk("post_strobe_ready", 0, {15'd0, din_ready}, 16'd1);
    @(posedge clock);
    #1;
    chk("pulse_width", 0, {15'd0, dout_valid}, 16'd0);

    // FIFO with random gaps; garbage on din while not valid.
    accepted = 0;
    cyc = 0;
    while (accepted < 8 && cyc < 200) begin
      @(negedge clock);
      if ($urandom_range(0, 1) == 1)
        drive(1'b0, 1'b0, 4'd8, 16'h2000 + 16'(accepted), 1'b1, 1'b0, 1'b0);
      else
        drive(1'b0, 1'b0, 4'd8, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      #1;
      chk("gap_ready", cyc, {15'd0, din_ready}, 16'd1);
      @(posedge clock);
      if (din_valid) accepted++;
      #1;
      chk("gap_dvld", cyc, {15'd0, dout_valid}, 16'd0);
      cyc++;
    end
    chk("gap_accepted", 0, 16'(accepted), 16'd8);
    @(negedge clock);
    drive(1'b0, 1'b0, 4'd8, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    chk("gap_dvld_strobe", 0, {15'd0, dout_valid}, 16'd1);
    for (int k = 0; k < 8; k++) chk("gap_dout", k, douts[k], 16'h2000 + 16'(k));
    chk("gap_underrun", 0, {15'd0, underrun}, 16'd0);

    @(negedge clock);
    drive(1'b0, 1'b0, 4'd8, 16'h0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch_demux.md
# ch_demux

Transmit-side channel deinterleaver: pops a serial stream of 16-bit channel words from the TX FIFO (channel 0 first, one word per active channel per frame) and assembles them into a complete frame. On each `sample_strobe` from the interpolator side, it presents the frame on eight parallel per-channel outputs. It is the inverse of the RX-side channel multiplexer that serialises channel data into the RX FIFO. It sits between the TX FIFO read port and the per-channel interpolator inputs.

## Interface
- No parameters; channel count is a run-time input.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; full reset of state and outputs.
- `clear`  in  1  synchronous flush. Same effect as `reset` except `underrun` is kept.
- `channels`  in  4  active channel count (1..8). Values 0 and 9..15 are treated as 8.
- `din`  in  16  FIFO read data.
- `din_valid`  in  1  FIFO not empty; `din` valid.
- `din_ready`  out  1  pop request. A word is consumed on a cycle where `din_valid & din_ready` is high.
- `sample_strobe`  in  1  one-cycle request for the next frame.
- `dout0`..`dout7`  out  16 each  per-channel sample outputs; registered.
- `dout_valid`  out  1  one-cycle pulse; `doutN` updated this cycle.
- `underrun`  out  1  sticky; a strobe arrived with no complete frame.
- `clear_status`  in  1  clears `underrun`.

## Operation
- Internal storage:
  - Holding registers `hold0..7` (16 b each).
  - Write index `idx` (3 b).
  - Latched count `nch` (1..8).
  - State `FILL` / `FULL`.
- Reset/clear values:
  - state=`FILL`, `idx`=0, `nch`=sanitised `channels`, `hold*`=0.
  - `dout0..7`=0, `dout_valid`=0, `din_ready`=0 during the reset cycle.
  - `underrun`=0 on `reset` only.
- `nch` reloads from `channels` every cycle in which state=`FILL` and `idx`=0. Changing `channels` mid-frame takes effect at the next frame boundary.
- `din_ready` is combinational: high iff state=`FILL` and not in reset/clear.
- FILL behaviour:
  - On accept: `hold[idx]`<=`din`.
  - If `idx`==`nch`-1: `idx`<=0 and state<=`FULL`; otherwise `idx`<=`idx`+1.
- FULL behaviour:
  - No pops.
  - On `sample_strobe`: `doutK`<=`holdK` for K<`nch`, `doutK`<=0 for K>=`nch`.
  - `dout_valid`<=1 and state<=`FILL`.
- Underrun: `sample_strobe` while state=`FILL` produces:
  - all `doutK`<=0,
  - `dout_valid`<=1,
  - `underrun`<=1.
  - A partially assembled frame is kept, and filling continues.
- Same-cycle final word and strobe: a strobe in the same cycle as the accept of the last word of a frame is an underrun, because the state is still `FILL`. The completed frame waits in `FULL` for the next strobe.
- Same-cycle `clear_status` and underrun event: `underrun` ends at 1 (set wins).
- `clear` and `reset` override all other inputs in their cycle. No pop occurs and no `dout_valid` is produced.
- `doutN` holds its value between strobes.

## Timing
- Pop latency: `din` must be valid in the same cycle as `din_valid & din_ready`. The FIFO is show-ahead.
- Frame assembly takes a minimum of `nch` clock cycles with `din_valid` held high.
- Strobe to output: `doutN` and `dout_valid` are registered and update 1 cycle after the `sample_strobe` cycle.
- `dout_valid` is high exactly 1 cycle per strobe, including on underrun.
- The first accept after `FULL`→`FILL` can happen 1 cycle after the strobe cycle.
- Sustained rate with `nch`=N and no underrun requires strobe spacing >= N+1 cycles.
- `underrun` rises 1 cycle after the offending strobe.

## Test plan
- Basic 8-channel frame:
  - Stimulus: `channels`=8; feed words 0x1000..0x1007 back-to-back, then strobe.
  - Response: `dout0..7`=0x1000..0x1007, one `dout_valid` pulse, `din_ready` low from frame complete until 1 cycle after the strobe.
- Partial channel count:
  - Stimulus: `channels`=2; feed 0xAAAA, 0x5555, 0x1111, 0x2222 with strobes after each pair.
  - Response: first strobe gives `dout0`=0xAAAA, `dout1`=0x5555, `dout2..7`=0; second gives 0x1111/0x2222. `idx` wraps correctly.
- Underrun:
  - Stimulus: `channels`=4; feed 2 words, then strobe.
  - Response: all `dout`=0, `dout_valid` pulse, `underrun`=1.
  - Continue: feed 2 more words, strobe again. Frame appears correctly; `underrun` stays 1 until `clear_status`.
- Same-cycle final word and strobe:
  - Stimulus: strobe coincident with the accept of the last word.
  - Response: underrun set and zeros output. The next strobe outputs the completed frame.
- FIFO gaps:
  - Stimulus: `din_valid` toggled 1/0 randomly during filling.
  - Response: only valid-and-ready words are stored, in order; no duplicates or drops.
- Mid-frame flush:
  - Stimulus: `clear` after 3 of 8 words, then `channels`=3 and 3 new words, then strobe.
  - Response: outputs are only the new 3 words; `underrun` is preserved across `clear` and zeroed by `reset`.
